// File: rtl/uart_com_loader.sv
// Boot loader: parses the MAGIC0/MAGIC1/length framing from the RX byte stream,
// packs the payload into masked little-endian SDRAM word writes, then releases the CPU.
module uart_com_loader #(
  parameter logic [24:0] BASE_ADDR      = 25'h0000040,
  parameter logic [7:0]  MAGIC0         = 8'h11,
  parameter logic [7:0]  MAGIC1         = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_rx_tvalid,
  output logic        s_axis_rx_tready,
  input  logic [7:0]  s_axis_rx_tdata,
  output logic        m_axis_sdram_req_tvalid,
  input  logic        m_axis_sdram_req_tready,
  output logic [63:0] m_axis_sdram_req_tdata,
  output logic [15:0] load_len,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_error,
  output logic        cpu_resetn
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    WAIT_M0, WAIT_M1, LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERROR
  } state_t;

  state_t        state_q;
  logic [15:0]   len_q;
  logic [15:0]   cnt_q;
  logic [31:0]   word_q, word_d;
  logic [3:0]    mask_q, mask_d;
  logic [24:0]   addr_q;
  logic          req_vld_q;
  logic [TW-1:0] to_q;
  logic          done_q;
  logic          err_q;

  logic       rx_fire, req_fire, last_byte, to_run, to_hit;
  logic [1:0] lane;

  // A pending request blocks the RX side; FLUSH always has one pending.
  assign s_axis_rx_tready = !req_vld_q && (state_q != FLUSH);
  assign rx_fire          = s_axis_rx_tvalid && s_axis_rx_tready;
  assign req_fire         = req_vld_q && m_axis_sdram_req_tready;
  assign lane             = cnt_q[1:0];
  assign last_byte        = (cnt_q == len_q - 16'd1);

  assign to_run = (state_q == WAIT_M1) || (state_q == LEN_HI) ||
                  (state_q == LEN_LO)  || (state_q == DATA);
  // An arriving byte wins over an expiring timeout.
  assign to_hit = to_run && !rx_fire && !req_vld_q &&
                  (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    word_d[8*lane +: 8] = s_axis_rx_tdata;
    mask_d[lane]        = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_M0;
      len_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      mask_q    <= '0;
      addr_q    <= '0;
      req_vld_q <= 1'b0;
      to_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (rx_fire)
        to_q <= '0;
      else if (to_run && !req_vld_q)
        to_q <= to_q + 1'b1;

      if (to_hit) begin
        state_q <= ERROR;
        err_q   <= 1'b1;
        word_q  <= '0;
        mask_q  <= '0;
        to_q    <= '0;
      end else begin
        case (state_q)
          WAIT_M0: if (rx_fire && s_axis_rx_tdata == MAGIC0) state_q <= WAIT_M1;
          WAIT_M1: if (rx_fire) begin
            if (s_axis_rx_tdata == MAGIC1)      state_q <= LEN_HI;
            else if (s_axis_rx_tdata != MAGIC0) state_q <= WAIT_M0;
          end
          LEN_HI: if (rx_fire) begin
            len_q[15:8] <= s_axis_rx_tdata;
            state_q     <= LEN_LO;
          end
          LEN_LO: if (rx_fire) begin
            len_q[7:0] <= s_axis_rx_tdata;
            cnt_q      <= '0;
            if ({len_q[15:8], s_axis_rx_tdata} == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            if (req_fire) begin
              req_vld_q <= 1'b0;
              word_q    <= '0;
              mask_q    <= '0;
            end else if (rx_fire) begin
              word_q <= word_d;
              mask_q <= mask_d;
              cnt_q  <= cnt_q + 16'd1;
              if (lane == 2'd3 || last_byte) begin
                req_vld_q <= 1'b1;
                addr_q    <= BASE_ADDR + {11'd0, cnt_q[15:2]};
              end
              if (last_byte) state_q <= FLUSH;
            end
          end
          FLUSH: if (req_fire) begin
            req_vld_q <= 1'b0;
            word_q    <= '0;
            mask_q    <= '0;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign m_axis_sdram_req_tvalid = req_vld_q;
  assign m_axis_sdram_req_tdata  = req_vld_q ? {1'b1, mask_q, 2'b00, addr_q, word_q} : 64'd0;
  assign load_len   = len_q;
  assign load_busy  = to_run || (state_q == FLUSH);
  assign load_done  = done_q;
  assign load_error = err_q;
  assign cpu_resetn = done_q;

endmodule

// File: tb/tb_uart_com_loader.sv
// Bench for uart_com_loader: randomized byte streams and SDRAM backpressure
// checked against a byte-queue frame model, plus fixed frames with literal results.
module tb_uart_com_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic [7:0]  rx_tdata = 8'h00;
  logic        req_tvalid;
  logic        req_tready = 1'b0;
  logic [63:0] req_tdata;
  logic [15:0] load_len;
  logic        load_busy, load_done, load_error, cpu_resetn;

  int total = 0;
  int bad   = 0;
  logic bp_hold = 1'b0;

  uart_com_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .s_axis_rx_tvalid(rx_tvalid), .s_axis_rx_tready(rx_tready), .s_axis_rx_tdata(rx_tdata),
    .m_axis_sdram_req_tvalid(req_tvalid), .m_axis_sdram_req_tready(req_tready),
    .m_axis_sdram_req_tdata(req_tdata),
    .load_len(load_len), .load_busy(load_busy), .load_done(load_done),
    .load_error(load_error), .cpu_resetn(cpu_resetn)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    req_tready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Frame model: bytes in acceptance order, expected request words out.
  int          m_phase;
  logic [15:0] m_len;
  int          m_k;
  logic [7:0]  m_bytes[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  task automatic model_accept(input logic [7:0] b);
    logic [31:0] data;
    logic [3:0]  mask;
    logic [24:0] addr;
    case (m_phase)
      0: if (b == 8'h11) m_phase = 1;
      1: if (b == 8'h55) m_phase = 2; else if (b != 8'h11) m_phase = 0;
      2: begin m_len[15:8] = b; m_phase = 3; end
      3: begin
        m_len[7:0] = b; m_k = 0; m_bytes.delete();
        m_phase = (m_len == 16'd0) ? 5 : 4;
      end
      4: begin
        m_bytes.push_back(b);
        m_k++;
        if (m_bytes.size() == 4 || m_k == int'(m_len)) begin
          data = '0; mask = '0;
          for (int i = 0; i < m_bytes.size(); i++) begin
            data = data | (32'(m_bytes[i]) << (8 * i));
            mask[i] = 1'b1;
          end
          addr = 25'(32'h40 + (m_k - 1) / 4);
          exp_q.push_back({1'b1, mask, 2'b00, addr, data});
          m_bytes.delete();
        end
        if (m_k == int'(m_len)) m_phase = 5;
      end
      default: ;
    endcase
  endtask

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0; m_len = '0; m_k = 0; m_bytes.delete(); exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (req_tvalid) begin
        total++;
        if (rx_tready) begin bad++; $display("FAIL rx_ready_while_req act=1 exp=0"); end
      end
      if (prev_stall) begin
        total++;
        if (!req_tvalid || req_tdata !== prev_data) begin
          bad++; $display("FAIL req_hold act=%h exp=%h", req_tdata, prev_data);
        end
      end
      if (req_tvalid && req_tready) begin
        obs_q.push_back(req_tdata);
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL extra_req act=%h exp=none", req_tdata);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if (req_tdata !== e) begin bad++; $display("FAIL req_word act=%h exp=%h", req_tdata, e); end
        end
      end
      if (rx_tvalid && rx_tready) model_accept(rx_tdata);
      total++;
      if (cpu_resetn !== load_done) begin
        bad++; $display("FAIL cpu_resetn act=%b exp=%b", cpu_resetn, load_done);
      end
      prev_stall = req_tvalid && !req_tready;
      prev_data  = req_tdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s act=%h exp=%h", name, act, exp); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; rx_tvalid = 1'b0; bp_hold = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rx_tdata = b; rx_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_tready) break;
      n++;
      if (n > 2000) begin bad++; total++; $display("FAIL rx_accept_timeout act=stalled exp=accepted"); break; end
    end
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    rx_tdata = 8'($urandom);
  endtask

  logic [7:0] payload[256];

  task automatic send_frame(input int len);
    send_byte(8'h11); send_byte(8'h55);
    send_byte(8'(len >> 8)); send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(payload[i]);
  endtask

  task automatic check_end(input int len);
    int n = 0;
    while (!load_done && n < 2000) begin @(negedge clk); n++; end
    chk("load_done", 64'(load_done), 64'd1);
    chk("cpu_resetn_end", 64'(cpu_resetn), 64'd1);
    chk("load_len", 64'(load_len), 64'(len));
    chk("load_busy_end", 64'(load_busy), 64'd0);
    chk("load_error_end", 64'(load_error), 64'd0);
    chk("pending_words", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    chk("rst_rx_tready", 64'(rx_tready), 64'd1);
    chk("rst_req_tvalid", 64'(req_tvalid), 64'd0);
    chk("rst_req_tdata", req_tdata, 64'd0);
    chk("rst_load_len", 64'(load_len), 64'd0);
    chk("rst_busy", 64'(load_busy), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_error", 64'(load_error), 64'd0);
    chk("rst_cpu_resetn", 64'(cpu_resetn), 64'd0);
  endtask

  logic sent;

  initial begin
    logic [63:0] held;
    int n, len;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals();

    // Nominal frame
    do_reset();
    payload[0] = 8'hA0; payload[1] = 8'hA1; payload[2] = 8'hA2; payload[3] = 8'hA3;
    payload[4] = 8'hB0; payload[5] = 8'hB1;
    send_frame(6);
    check_end(6);
    chk("nom_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      chk("nom_w0", obs_q[0], {1'b1, 4'b1111, 2'b00, 25'h40, 32'hA3A2A1A0});
      chk("nom_w1", obs_q[1], {1'b1, 4'b0011, 2'b00, 25'h41, 32'h0000B1B0});
    end

    // Resync on noise and repeated MAGIC0
    do_reset();
    send_byte(8'h22); send_byte(8'h11); send_byte(8'h11); send_byte(8'h55);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h7E);
    check_end(1);
    chk("resync_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1)
      chk("resync_w0", obs_q[0], {1'b1, 4'b0001, 2'b00, 25'h40, 32'h0000007E});

    // Zero length
    do_reset();
    send_byte(8'h11); send_byte(8'h55); send_byte(8'h00); send_byte(8'h00);
    chk("zero_done", 64'(load_done), 64'd1);
    send_byte(8'h11); send_byte(8'h55); send_byte(8'h00);
    chk("zero_no_req", 64'(obs_q.size()), 64'd0);
    chk("zero_done_sticky", 64'(load_done), 64'd1);

    // Backpressure on the first word
    do_reset();
    for (int i = 0; i < 7; i++) payload[i] = 8'($urandom);
    bp_hold = 1'b1; sent = 1'b0;
    fork begin send_frame(7); sent = 1'b1; end join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!req_tvalid && n < 2000);
    chk("bp_req_seen", 64'(req_tvalid), 64'd1);
    held = req_tdata;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_rx_tready", 64'(rx_tready), 64'd0);
      chk("bp_tdata_stable", req_tdata, held);
    end
    bp_hold = 1'b0;
    n = 0;
    while (!sent && n < 4000) begin @(negedge clk); n++; end
    chk("bp_sender_done", 64'(sent), 64'd1);
    check_end(7);
    chk("bp_count", 64'(obs_q.size()), 64'd2);

    // Timeout after a partial word
    do_reset();
    send_byte(8'h11); send_byte(8'h55); send_byte(8'h00); send_byte(8'h08);
    send_byte(8'hC0); send_byte(8'hC1);
    repeat (99) @(posedge clk);
    #1;
    chk("to_not_yet", 64'(load_error), 64'd0);
    chk("to_busy", 64'(load_busy), 64'd1);
    @(posedge clk); #1;
    chk("to_error", 64'(load_error), 64'd1);
    chk("to_busy_off", 64'(load_busy), 64'd0);
    chk("to_cpu_held", 64'(cpu_resetn), 64'd0);
    send_byte(8'h33);
    chk("to_no_req", 64'(obs_q.size()), 64'd0);
    chk("to_error_sticky", 64'(load_error), 64'd1);

    // Reset mid-load, then a clean frame
    do_reset();
    send_byte(8'h11); send_byte(8'h55); send_byte(8'h00); send_byte(8'h0A);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    repeat (2) @(posedge clk);
    do_reset();
    check_reset_vals();
    for (int i = 0; i < 9; i++) payload[i] = 8'($urandom);
    send_frame(9);
    check_end(9);
    chk("rml_count", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() > 0) chk("rml_first_addr", 64'(obs_q[0][56:32]), 64'h40);

    // Randomized frames with noise prefixes
    for (int t = 0; t < 8; t++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] nb;
        nb = 8'($urandom);
        if (nb == 8'h11) nb = 8'h12;
        send_byte(nb);
      end
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
      send_frame(len);
      check_end(len);
      chk("rand_count", 64'(obs_q.size()), 64'((len + 3) / 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_com_loader.md
Name: uart_com_loader

Overview:
Boot-time sequencer between the UART RX byte stream and the SDRAM request port.
- Parses the loader framing: MAGIC0, MAGIC1, length high byte, length low byte, then payload.
- Packs payload bytes into little-endian 32-bit words and issues masked SDRAM writes from BASE_ADDR upward.
- Holds the CPU in reset until the image is fully written, then releases it.

Parameters:
- BASE_ADDR, 25'h0000040, SDRAM word address of payload byte 0.
- MAGIC0, 8'h11, first framing byte.
- MAGIC1, 8'h55, second framing byte.
- TIMEOUT_CYCLES, 100_000_000, maximum idle cycles between bytes once framing has started.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axis_rx_tvalid  in  1  RX byte valid
- s_axis_rx_tready  out  1  RX byte accept
- s_axis_rx_tdata  in  8  RX byte
- m_axis_sdram_req_tvalid  out  1  write request valid
- m_axis_sdram_req_tready  in  1  write request accept
- m_axis_sdram_req_tdata  out  64  request word:
  - [63] write flag, always 1
  - [62:59] byte mask, 1 = write lane
  - [58:57] reserved, 0
  - [56:32] word address
  - [31:0] data
- load_len  out  16  received length field
- load_busy  out  1  framing in progress
- load_done  out  1  sticky: image written
- load_error  out  1  sticky: timeout
- cpu_resetn  out  1  CPU reset, 0 until load_done

Behaviour:
- Reset values:
  - FSM = WAIT_M0.
  - All outputs 0, except s_axis_rx_tready = 1.
  - Byte counter, word register, mask and timeout counter cleared.
  - Reset mid-load abandons the load; any pending request is dropped (tvalid low next cycle).
- States: WAIT_M0, WAIT_M1, LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERROR.
- WAIT_M0: accepting MAGIC0 -> WAIT_M1; any other byte is discarded.
- WAIT_M1:
  - MAGIC1 -> LEN_HI.
  - MAGIC0 -> stay in WAIT_M1.
  - Other byte -> WAIT_M0.
- LEN_HI -> LEN_LO: latch load_len[15:8].
- LEN_LO: latch load_len[7:0].
  - Length 0 -> DONE.
  - Otherwise -> DATA.
- DATA, per accepted byte k (0-based, 16-bit counter):
  - Written to lane k[1:0]; mask bit k[1:0] set.
  - Word address = BASE_ADDR + k[15:2], 25-bit wrap.
  - Request is presented the cycle after the 4th lane fills, or after the last byte (k = load_len-1) with a partial mask.
- Backpressure: while m_axis_sdram_req_tvalid = 1, s_axis_rx_tready = 0. tvalid, tdata and mask are held stable until tready.
  - On handshake, mask and word register clear.
  - If the handshake is the final word -> DONE; otherwise -> DATA.
- FLUSH: entered after the last byte is accepted; waits for the request handshake, then -> DONE.
- load_busy = 1 in WAIT_M1, LEN_HI, LEN_LO, DATA and FLUSH.
- Timeout counter:
  - Runs in WAIT_M1, LEN_HI, LEN_LO and DATA.
  - Cleared on every accepted byte; frozen while a request is pending.
  - Reaching TIMEOUT_CYCLES -> ERROR; a partial word is discarded, not written.
- DONE:
  - load_done = 1 and cpu_resetn = 1, both set in the same cycle and sticky until reset.
  - s_axis_rx_tready = 1; bytes are consumed and ignored, so the RX path belongs to the CPU UART.
- ERROR:
  - load_error = 1, sticky; cpu_resetn stays 0.
  - s_axis_rx_tready = 1, bytes discarded; only reset exits ERROR.
- Simultaneous events:
  - A byte arriving in the same cycle the timeout expires is accepted, and the timeout does not fire.
  - An RX byte is never accepted in a cycle where the request is valid.
- Throughput: at most 1 byte per cycle, plus 1 stall cycle per issued word.

Test Plan:
- Nominal: 11 55 00 06 A0 A1 A2 A3 B0 B1 with BASE_ADDR = 0x40 -> two requests:
  - word 0x40, mask 1111, data A3A2A1A0.
  - word 0x41, mask 0011, data 0000B1B0.
  - Then load_done = 1, cpu_resetn = 1, load_len = 6.
- Framing resync: 22 11 11 55 00 01 7E -> one request, word 0x40, mask 0001, data 0000007E.
- Zero length: 11 55 00 00 -> no request; load_done = 1 within 1 cycle of the last byte; subsequent bytes are accepted and ignored.
- Backpressure: req_tready held 0 for 20 cycles on the first word:
  - s_axis_rx_tready = 0 and tdata stable throughout.
  - After release, the remaining bytes are written correctly.
- Timeout: TIMEOUT_CYCLES = 100; send 11 55 00 08 C0 C1 then stop -> after 100 idle cycles:
  - load_error = 1.
  - No request issued.
  - cpu_resetn stays 0.
- Reset mid-load: assert reset after 3 payload bytes -> all outputs return to reset values; a fresh full frame then loads correctly from word 0x40.
